pe_mac: RTL and testbench

- One processing element (PE) of an 8-PE systolic MAC chain in the NPU core.
- A feature ("m") stream of 8 beats passes through the chain; each PE captures the beat whose index equals its i_mac_id.
- A weight ("w") stream of 32 beats then passes through. For each weight beat, the PE computes the dot product of the beat with its captured feature vector and stores it in result lane o_count.
- Both streams are forwarded to the next PE with a 1-cycle register delay.

---
 rtl/pe_mac_pkg.sv | 21 ++
 rtl/pe_mac_dot32.sv | 17 +
 rtl/pe_mac.sv | 130 +++++++++++++
 tb/tb_pe_mac.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_mac_pkg.sv
// Shared constants and element helpers for the pe_mac systolic processing element.
package pe_mac_pkg;

   localparam int unsigned DATA_WIDTH  = 8;
   localparam int unsigned DATA_NUM    = 32;
   localparam int unsigned BEAT_WIDTH  = DATA_NUM * DATA_WIDTH;
   localparam int unsigned ACC_WIDTH   = 2 * DATA_WIDTH;
   localparam int unsigned DOT_WIDTH   = 21;
   localparam int unsigned MAX_COUNT   = 32;
   localparam int unsigned COUNT_WIDTH = 6;
   localparam int unsigned LANE_IDX_W  = 5;
   localparam int unsigned MCNT_WIDTH  = 3;

   function automatic logic signed [DATA_WIDTH-1:0] elem(
      input logic [BEAT_WIDTH-1:0] beat,
      input int unsigned           k
   );
      return $signed(beat[k*DATA_WIDTH +: DATA_WIDTH]);
   endfunction

endpackage

// File: rtl/pe_mac_dot32.sv
// Combinational signed dot product of two 32-element beats; 21 bits holds the full-range sum.
module pe_dot32
   import pe_mac_pkg::*;
(
   input  logic        [BEAT_WIDTH-1:0] a,
   input  logic        [BEAT_WIDTH-1:0] b,
   output logic signed [DOT_WIDTH-1:0]  dot
);

   always_comb begin
      dot = '0;
      for (int unsigned k = 0; k < DATA_NUM; k++) begin
         dot = dot + DOT_WIDTH'(elem(a, k)) * DOT_WIDTH'(elem(b, k));
      end
   end

endmodule

// File: rtl/pe_mac.sv
// One PE of the 8-deep systolic MAC chain: forwards both streams, captures its feature
// beat and accumulates one dot product per weight beat into successive result lanes.
module pe_mac
   import pe_mac_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = pe_mac_pkg::DATA_WIDTH,
   parameter int unsigned DATA_NUM   = pe_mac_pkg::DATA_NUM
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_mac_en,
   input  logic [MCNT_WIDTH-1:0]               i_mac_id,
   input  logic [DATA_NUM*DATA_WIDTH-1:0]      i_wdata,
   input  logic                                i_wdata_vld,
   input  logic [DATA_NUM*DATA_WIDTH-1:0]      i_mdata,
   input  logic                                i_mdata_vld,
   input  logic                                i_mac_clear,
   output logic [DATA_NUM*DATA_WIDTH-1:0]      o_wdata,
   output logic                                o_wdata_vld,
   output logic [DATA_NUM*DATA_WIDTH-1:0]      o_mdata,
   output logic                                o_mdata_vld,
   output logic [DATA_NUM*2*DATA_WIDTH-1:0]    o_mac_result,
   output logic [COUNT_WIDTH-1:0]              o_count,
   output logic [DATA_NUM*DATA_WIDTH-1:0]      o_r_wdata,
   output logic                                o_r_wdata_vld,
   output logic [DATA_NUM*DATA_WIDTH-1:0]      o_r_mdata,
   output logic                                o_r_mdata_vld
);

   logic [DATA_NUM*DATA_WIDTH-1:0] fwd_wdata;
   logic                           fwd_wdata_vld;
   logic [DATA_NUM*DATA_WIDTH-1:0] fwd_mdata;
   logic                           fwd_mdata_vld;

   logic [MCNT_WIDTH-1:0]          mcnt;
   logic [COUNT_WIDTH-1:0]         count;
   logic [2*DATA_WIDTH-1:0]        lane [DATA_NUM];
   logic [DATA_NUM*DATA_WIDTH-1:0] r_wdata;
   logic                           r_wdata_vld;
   logic [DATA_NUM*DATA_WIDTH-1:0] r_mdata;
   logic                           r_mdata_vld;

   logic signed [DOT_WIDTH-1:0]    dot;
   logic                           accept_w;
   logic                           accept_m;
   logic [LANE_IDX_W-1:0]          lane_idx;

   // r_mdata is zero until a capture, so an uncaptured PE naturally yields dot = 0.
   pe_dot32 u_dot (
      .a   (i_wdata),
      .b   (r_mdata),
      .dot (dot)
   );

   assign accept_w = i_wdata_vld && i_mac_en && (count < COUNT_WIDTH'(MAX_COUNT));
   assign accept_m = i_mdata_vld && i_mac_en;
   assign lane_idx = count[LANE_IDX_W-1:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fwd_wdata     <= '0;
         fwd_wdata_vld <= 1'b0;
         fwd_mdata     <= '0;
         fwd_mdata_vld <= 1'b0;
      end else begin
         fwd_wdata_vld <= i_wdata_vld;
         fwd_mdata_vld <= i_mdata_vld;
         if (i_wdata_vld) fwd_wdata <= i_wdata;
         if (i_mdata_vld) fwd_mdata <= i_mdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mcnt        <= '0;
         count       <= '0;
         r_wdata     <= '0;
         r_wdata_vld <= 1'b0;
         r_mdata     <= '0;
         r_mdata_vld <= 1'b0;
      end else if (i_mac_clear) begin
         mcnt        <= '0;
         count       <= '0;
         r_wdata_vld <= 1'b0;
         r_mdata     <= '0;
         r_mdata_vld <= 1'b0;
      end else begin
         r_wdata_vld <= accept_w;
         if (accept_w) begin
            count   <= count + 1'b1;
            r_wdata <= i_wdata;
         end
         if (accept_m) begin
            mcnt <= mcnt + 1'b1;
            if (mcnt == i_mac_id) begin
               r_mdata     <= i_mdata;
               r_mdata_vld <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_mac_clear) begin
         for (int unsigned j = 0; j < DATA_NUM; j++) begin
            lane[j] <= '0;
         end
      end else if (accept_w) begin
         lane[lane_idx] <= lane[lane_idx] + dot[2*DATA_WIDTH-1:0];
      end
   end

   always_comb begin
      o_mac_result = '0;
      for (int unsigned j = 0; j < DATA_NUM; j++) begin
         o_mac_result[j*2*DATA_WIDTH +: 2*DATA_WIDTH] = lane[j];
      end
   end

   assign o_wdata       = fwd_wdata;
   assign o_wdata_vld   = fwd_wdata_vld;
   assign o_mdata       = fwd_mdata;
   assign o_mdata_vld   = fwd_mdata_vld;
   assign o_count       = count;
   assign o_r_wdata     = r_wdata;
   assign o_r_wdata_vld = r_wdata_vld;
   assign o_r_mdata     = r_mdata;
   assign o_r_mdata_vld = r_mdata_vld;

endmodule

// File: tb/tb_pe_mac.sv
// Bench for pe_mac: fill-pattern vector table, directed corner sequences and a random
// phase, all checked every cycle against a lane-array reference model.
module tb_pe_mac;

   logic         clk = 1'b0;
   logic         rst, mac_en, mac_clear;
   logic [2:0]   mac_id;
   logic [255:0] wdata, mdata;
   logic         wdata_vld, mdata_vld;
   logic [255:0] o_wdata, o_mdata, o_r_wdata, o_r_mdata;
   logic         o_wdata_vld, o_mdata_vld, o_r_wdata_vld, o_r_mdata_vld;
   logic [511:0] o_mac_result;
   logic [5:0]   o_count;

   int checks = 0;
   int passed = 0;

   // reference model state
   logic [255:0] e_wdata, e_mdata, e_r_wdata, e_r_mdata;
   logic         e_wvld, e_mvld, e_rwv, e_rmv;
   int           e_mcnt, e_count;
   int           e_lane [32];

   typedef struct {
      logic [2:0]  id;
      logic [7:0]  f;
      logic [7:0]  w;
      logic [15:0] lane0;
   } vec_t;
   vec_t tbl [7];

   always #5 clk = ~clk;

   pe_mac dut (
      .i_clk(clk), .i_rst(rst), .i_mac_en(mac_en), .i_mac_id(mac_id),
      .i_wdata(wdata), .i_wdata_vld(wdata_vld), .i_mdata(mdata), .i_mdata_vld(mdata_vld),
      .i_mac_clear(mac_clear),
      .o_wdata(o_wdata), .o_wdata_vld(o_wdata_vld), .o_mdata(o_mdata), .o_mdata_vld(o_mdata_vld),
      .o_mac_result(o_mac_result), .o_count(o_count),
      .o_r_wdata(o_r_wdata), .o_r_wdata_vld(o_r_wdata_vld),
      .o_r_mdata(o_r_mdata), .o_r_mdata_vld(o_r_mdata_vld)
   );

   function automatic logic [255:0] fill(input logic [7:0] b);
      return {32{b}};
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   function automatic int ref_dot(input logic [255:0] w, input logic [255:0] m);
      int s = 0;
      for (int k = 0; k < 32; k++) s += int'($signed(w[8*k +: 8])) * int'($signed(m[8*k +: 8]));
      return s;
   endfunction

   function automatic logic [511:0] exp_result();
      logic [511:0] r;
      int           v;
      for (int j = 0; j < 32; j++) begin
         v = e_lane[j];
         r[16*j +: 16] = v[15:0];
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic model_step();
      int d;
      if (rst) begin
         e_wdata = '0; e_mdata = '0; e_r_wdata = '0; e_r_mdata = '0;
         e_wvld = 0; e_mvld = 0; e_rwv = 0; e_rmv = 0; e_mcnt = 0; e_count = 0;
         for (int j = 0; j < 32; j++) e_lane[j] = 0;
      end else begin
         e_wvld = wdata_vld;
         e_mvld = mdata_vld;
         if (wdata_vld) e_wdata = wdata;
         if (mdata_vld) e_mdata = mdata;
         if (mac_clear) begin
            e_mcnt = 0; e_count = 0; e_r_mdata = '0; e_rmv = 0; e_rwv = 0;
            for (int j = 0; j < 32; j++) e_lane[j] = 0;
         end else begin
            e_rwv = 0;
            if (wdata_vld && mac_en && e_count < 32) begin
               d = ref_dot(wdata, e_r_mdata);
               e_lane[e_count] = (e_lane[e_count] + d) & 32'hFFFF;
               e_count++;
               e_r_wdata = wdata;
               e_rwv = 1;
            end
            if (mdata_vld && mac_en) begin
               if (e_mcnt == int'(mac_id)) begin
                  e_r_mdata = mdata;
                  e_rmv = 1;
               end
               e_mcnt = (e_mcnt + 1) % 8;
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("o_wdata", o_wdata, e_wdata);
      chk("o_wdata_vld", o_wdata_vld, e_wvld);
      chk("o_mdata", o_mdata, e_mdata);
      chk("o_mdata_vld", o_mdata_vld, e_mvld);
      chk("o_mac_result", o_mac_result, exp_result());
      chk("o_count", o_count, e_count[5:0]);
      chk("o_r_wdata", o_r_wdata, e_r_wdata);
      chk("o_r_wdata_vld", o_r_wdata_vld, e_rwv);
      chk("o_r_mdata", o_r_mdata, e_r_mdata);
      chk("o_r_mdata_vld", o_r_mdata_vld, e_rmv);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle();
      wdata_vld = 0; mdata_vld = 0; mac_clear = 0;
   endtask

   task automatic do_reset();
      idle(); rst = 1; tick(); rst = 0;
   endtask

   task automatic do_clear();
      mac_clear = 1; tick(); mac_clear = 0;
   endtask

   task automatic feature_beats(input logic [2:0] id, input logic [255:0] sel, input bit by_index);
      mac_id = id;
      for (int k = 0; k < 8; k++) begin
         mdata_vld = 1;
         mdata = by_index ? fill(8'(k)) : ((k == int'(id)) ? sel : rnd256());
         tick();
      end
      mdata_vld = 0;
   endtask

   task automatic weight_beats(input int n, input logic [255:0] w);
      for (int i = 0; i < n; i++) begin
         wdata_vld = 1; wdata = w; tick();
      end
      wdata_vld = 0;
   endtask

   initial begin
      logic [255:0] p;
      logic [511:0] exp_r;

      tbl[0] = '{3'd0, 8'h01, 8'h01, 16'h0020};
      tbl[1] = '{3'd1, 8'hFF, 8'h01, 16'hFFE0};
      tbl[2] = '{3'd2, 8'h80, 8'h80, 16'h0000};
      tbl[3] = '{3'd3, 8'h7F, 8'h7F, 16'hE020};
      tbl[4] = '{3'd4, 8'h80, 8'h7F, 16'h1000};
      tbl[5] = '{3'd6, 8'h02, 8'h03, 16'h00C0};
      tbl[6] = '{3'd7, 8'h00, 8'h55, 16'h0000};

      rst = 1; mac_en = 0; mac_id = 0; mac_clear = 0;
      wdata = '0; mdata = '0; wdata_vld = 0; mdata_vld = 0;
      tick();
      rst = 0;
      chk("reset_count", o_count, 6'd0);
      chk("reset_result", o_mac_result, '0);
      chk("reset_r_mdata_vld", o_r_mdata_vld, 1'b0);

      // table: capture fill f at position id, one weight beat of fill w
      for (int r = 0; r < 7; r++) begin
         do_reset(); do_clear(); mac_en = 1;
         feature_beats(tbl[r].id, fill(tbl[r].f), 0);
         weight_beats(1, fill(tbl[r].w));
         chk("tbl_lane0", o_mac_result[15:0], tbl[r].lane0);
         chk("tbl_count", o_count, 6'd1);
         chk("tbl_r_mdata", o_r_mdata, fill(tbl[r].f));
      end

      // pattern test
      for (int k = 0; k < 32; k++) p[8*k +: 8] = (k % 2 == 1) ? 8'h02 : 8'h01;
      do_reset(); do_clear(); mac_en = 1; mac_id = 0;
      for (int k = 0; k < 8; k++) begin mdata_vld = 1; mdata = p; tick(); end
      mdata_vld = 0;
      weight_beats(32, p);
      chk("pat_r_mdata", o_r_mdata, p);
      chk("pat_count", o_count, 6'd32);
      chk("pat_result", o_mac_result, {32{16'h0050}});

      // capture by id
      do_reset(); do_clear(); mac_en = 1;
      feature_beats(3'd5, '0, 1);
      weight_beats(1, fill(8'h01));
      chk("id5_r_mdata", o_r_mdata, fill(8'h05));
      chk("id5_lane0", o_mac_result[15:0], 16'd160);
      chk("id5_count", o_count, 6'd1);

      // saturation and signedness
      do_reset(); do_clear(); mac_en = 1;
      feature_beats(3'd0, fill(8'hFF), 0);
      weight_beats(32, fill(8'h01));
      chk("sat_count32", o_count, 6'd32);
      chk("sat_result", o_mac_result, {32{16'hFFE0}});
      weight_beats(1, fill(8'h03));
      chk("sat_count33", o_count, 6'd32);
      chk("sat_result33", o_mac_result, {32{16'hFFE0}});
      chk("sat_no_rwv", o_r_wdata_vld, 1'b0);
      chk("sat_r_wdata", o_r_wdata, fill(8'h01));
      chk("sat_fwd", o_wdata, fill(8'h03));

      // clear together with a weight beat
      do_reset(); do_clear(); mac_en = 1;
      feature_beats(3'd0, fill(8'h02), 0);
      weight_beats(5, fill(8'h01));
      mac_clear = 1; wdata_vld = 1; wdata = fill(8'h09); tick();
      mac_clear = 0; wdata_vld = 0;
      chk("clr_count", o_count, 6'd0);
      chk("clr_result", o_mac_result, '0);
      chk("clr_r_mdata_vld", o_r_mdata_vld, 1'b0);
      chk("clr_r_mdata", o_r_mdata, '0);
      chk("clr_fwd_vld", o_wdata_vld, 1'b1);
      chk("clr_fwd", o_wdata, fill(8'h09));

      // enable low freezes compute
      feature_beats(3'd0, fill(8'h02), 0);
      weight_beats(3, fill(8'h01));
      mac_en = 0;
      weight_beats(4, fill(8'h01));
      feature_beats(3'd0, fill(8'h07), 0);
      exp_r = '0;
      for (int j = 0; j < 3; j++) exp_r[16*j +: 16] = 16'h0040;
      chk("en0_count", o_count, 6'd3);
      chk("en0_result", o_mac_result, exp_r);
      chk("en0_r_mdata", o_r_mdata, fill(8'h02));
      mac_en = 1;

      // reset mid-operation
      weight_beats(10, fill(8'h01));
      rst = 1; tick(); rst = 0;
      chk("rst_count", o_count, 6'd0);
      chk("rst_result", o_mac_result, '0);
      chk("rst_fwd", {o_wdata, o_mdata}, '0);
      chk("rst_vlds", {o_wdata_vld, o_mdata_vld, o_r_wdata_vld, o_r_mdata_vld}, 4'd0);
      chk("rst_regs", {o_r_wdata, o_r_mdata}, '0);

      // random phase
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         mac_clear = ($urandom_range(0, 59) == 0);
         mac_en    = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 99) == 0) mac_id = 3'($urandom_range(0, 7));
         mdata_vld = $urandom_range(0, 1) == 1;
         wdata_vld = $urandom_range(0, 1) == 1;
         mdata = rnd256();
         wdata = rnd256();
         tick();
      end
      rst = 0; idle(); tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
